// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller: size codes, FSM states
// and the lane-mask helper used by the store merge.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    // Byte lanes touched by an access; the reserved size touches none.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: byte_mask = 4'b0001 << off;
            SZ_HALF: byte_mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load lane select and sign/zero extension for a little-endian 32-bit word.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: data = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Single-port data memory controller with lane merge, extended loads and
// address-error reporting. Define DM_CLEAR_EN to zero the array after reset.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              exc_valid,
    output logic              exc_store,
    output logic [ADDR_W-1:0] exc_badaddr
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    state_t           state, state_n;
    logic             accept, illegal, misaligned, out_of_range;
    logic             do_store, do_load;
    logic [IDX_W-1:0] idx;
    logic [3:0]       mask;
    logic [31:0]      wlanes;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

    logic [31:0]      rd_word;
    logic [1:0]       rd_off, rd_size;
    logic             rd_uns;

    assign req_ready = !rst && (state == RUN);
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign mask      = byte_mask(req_size, req_addr[1:0]);

    // Any set address bit above the word index means the access is past the array.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_norange
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign illegal    = (req_size == 2'b11) || misaligned || out_of_range;
    assign do_store   = accept && !illegal && req_we;
    assign do_load    = accept && !illegal && !req_we;

    always_comb begin
        case (req_size)
            SZ_BYTE: wlanes = {4{req_wdata[7:0]}};
            SZ_HALF: wlanes = {2{req_wdata[15:0]}};
            default: wlanes = req_wdata;
        endcase
    end

`ifdef DM_CLEAR_EN
    logic [IDX_W-1:0] clr_cnt, clr_cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_n = clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(DEPTH - 1))
                state_n = RUN;
        end
    end

    assign clr_we  = !rst && (state == CLEAR);
    assign clr_idx = clr_cnt;
`else
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = RUN;
    end

    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // Storage has no reset; clearing and requests are mutually exclusive by req_ready.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++)
                if (mask[i])
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            exc_valid   <= 1'b0;
            exc_store   <= 1'b0;
            exc_badaddr <= '0;
            rd_word     <= '0;
            rd_off      <= '0;
            rd_size     <= '0;
            rd_uns      <= 1'b0;
        end else begin
            rsp_valid <= do_load;
            exc_valid <= accept && illegal;
            if (accept && illegal) begin
                exc_store   <= req_we;
                exc_badaddr <= req_addr;
            end
            if (do_load) begin
                rd_word <= mem[idx];
                rd_off  <= req_addr[1:0];
                rd_size <= req_size;
                rd_uns  <= req_unsigned;
            end
        end
    end

    dm_load_align u_align (
        .word (rd_word),
        .off  (rd_off),
        .size (rd_size),
        .uns  (rd_uns),
        .data (rsp_rdata)
    );

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed vector table, reset corners and
// randomized traffic against a byte-array reference model.
module tb_dm_ctrl;
    import dm_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
`ifdef DM_CLEAR_EN
    localparam int CLR_CYCLES = DEPTH;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, exc_valid, exc_store;
    logic [31:0] rsp_rdata, exc_badaddr;

    logic [31:0] al_word, al_data;
    logic [1:0]  al_off, al_size;
    logic        al_uns;

    always #5 clk = ~clk;

    dm_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .exc_valid    (exc_valid),
        .exc_store    (exc_store),
        .exc_badaddr  (exc_badaddr)
    );

    dm_load_align u_align (
        .word (al_word),
        .off  (al_off),
        .size (al_size),
        .uns  (al_uns),
        .data (al_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0]  mbytes [4*DEPTH];
    logic        m_rsp, m_exc, m_store;
    logic [31:0] m_rdata, m_bad;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rsp;
        logic        exc;
        logic        st;
        logic [31:0] rdata;
        logic [31:0] bad;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic uns);
        if (n == 4 || uns || !v[8*n-1])
            return v;
        return v | (32'hFFFF_FFFF << (8*n));
    endfunction

    task automatic modelStep(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        logic        legal;
        logic [31:0] val;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        legal = (size != 2'd3) && (addr % n == 0) && (addr < 4*DEPTH);
        m_rsp = legal && !we;
        m_exc = !legal;
        if (!legal) begin
            m_store = we;
            m_bad   = addr;
        end else if (we) begin
            for (int i = 0; i < n; i++)
                mbytes[addr+i] = 8'((wdata >> (8*i)) & 32'hFF);
        end else begin
            val = 0;
            for (int i = 0; i < n; i++)
                val = val | (32'(mbytes[addr+i]) << (8*i));
            m_rdata = extend(val, n, uns);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns one falling edge after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        modelStep(we, size, uns, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic releaseReset();
        int cycles;
        rst    = 1'b0;
        cycles = 0;
        #1;
        while (!req_ready && cycles < 3000) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("ready_latency", cycles, CLR_CYCLES);
        @(negedge clk);
`ifdef DM_CLEAR_EN
        for (int i = 0; i < 4*DEPTH; i++)
            mbytes[i] = 8'h00;
`endif
    endtask

    task automatic checkRandom(input string tag);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, m_rsp);
        checkOutput({tag, "_exc_valid"}, exc_valid, m_exc);
        if (m_rsp)
            checkOutput({tag, "_rdata"}, rsp_rdata, m_rdata);
        if (m_exc) begin
            checkOutput({tag, "_exc_store"}, exc_store, m_store);
            checkOutput({tag, "_badaddr"}, exc_badaddr, m_bad);
        end
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] a;
        logic [1:0]  sz;

        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,   32'h8765_4321, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,   32'h0,         1'b1, 1'b0, 1'b0, 32'h8765_4321, 32'h0};
        vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h13,   32'h0000_00A5, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h13,   32'h0,         1'b1, 1'b0, 1'b0, 32'hFFFF_FFA5, 32'h0};
        vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h13,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0};
        vecs[5]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,   32'h0,         1'b1, 1'b0, 1'b0, 32'hA565_4321, 32'h0};
        vecs[6]  = '{1'b1, SZ_HALF, 1'b0, 32'h12,   32'h0000_8001, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h12,   32'h0,         1'b1, 1'b0, 1'b0, 32'hFFFF_8001, 32'h0};
        vecs[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h10,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_4321, 32'h0};
        vecs[9]  = '{1'b0, SZ_BYTE, 1'b0, 32'h11,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0043, 32'h0};
        vecs[10] = '{1'b0, SZ_WORD, 1'b0, 32'h22,   32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h22};
        vecs[11] = '{1'b1, SZ_HALF, 1'b0, 32'h11,   32'h0000_FFFF, 1'b0, 1'b1, 1'b1, 32'h0,         32'h11};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'h10,   32'h0,         1'b1, 1'b0, 1'b0, 32'h8001_4321, 32'h0};
        vecs[13] = '{1'b0, 2'b11,   1'b0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0};
        vecs[14] = '{1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h1000};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        al_word = '0; al_off = '0; al_size = '0; al_uns = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset_req_ready", req_ready, 1'b0);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_exc_valid", exc_valid, 1'b0);
        checkOutput("reset_exc_store", exc_store, 1'b0);
        checkOutput("reset_exc_badaddr", exc_badaddr, 32'h0);
        releaseReset();

`ifdef DM_CLEAR_EN
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        checkOutput("cleared_load", rsp_rdata, 32'h0);
`endif

        $display("[TB] directed vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].rsp);
            checkOutput($sformatf("vec%0d_exc_valid", i), exc_valid, vecs[i].exc);
            if (vecs[i].rsp)
                checkOutput($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].rdata);
            if (vecs[i].exc) begin
                checkOutput($sformatf("vec%0d_exc_store", i), exc_store, vecs[i].st);
                checkOutput($sformatf("vec%0d_badaddr", i), exc_badaddr, vecs[i].bad);
            end
        end

        @(negedge clk);
        checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
        checkOutput("idle_exc_valid", exc_valid, 1'b0);
        checkOutput("hold_badaddr", exc_badaddr, 32'h1000);
        checkOutput("hold_exc_store", exc_store, 1'b0);
        checkOutput("hold_rdata", rsp_rdata, 32'h8001_4321);

        $display("[TB] reset corner cases");
        rst          = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = SZ_WORD;
        req_addr     = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_with_req_rsp_valid", rsp_valid, 1'b0);
        releaseReset();

        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        checkOutput("pre_rst_rsp_valid", rsp_valid, 1'b1);
        checkOutput("pre_rst_rdata", rsp_rdata, m_rdata);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_after_load_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_after_load_rdata", rsp_rdata, 32'h0);
        releaseReset();

`ifdef DM_CLEAR_EN
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        releaseReset();
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0);
        checkOutput("restart_clear_last_word", rsp_rdata, 32'h0);
`endif

        $display("[TB] randomized traffic");
        for (int w = 0; w < 64; w++)
            applyStimulus(1'b1, SZ_WORD, 1'b0, 32'(w*4), $urandom);
        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                a = $urandom | 32'h1000;
            else
                a = 32'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            checkRandom($sformatf("rnd%0d", i));
        end

        $display("[TB] standalone load align");
        for (int i = 0; i < 32; i++) begin
            al_word = $urandom;
            al_size = 2'($urandom_range(0, 2));
            al_uns  = 1'($urandom_range(0, 1));
            al_off  = 2'($urandom_range(0, 3));
            if (al_size == SZ_HALF)
                al_off = al_off & 2'b10;
            if (al_size == SZ_WORD)
                al_off = 2'b00;
            #1;
            if (al_size == SZ_BYTE)
                exp = extend((al_word >> (8*al_off)) & 32'hFF, 1, al_uns);
            else if (al_size == SZ_HALF)
                exp = extend((al_word >> (8*al_off)) & 32'hFFFF, 2, al_uns);
            else
                exp = al_word;
            checkOutput($sformatf("align%0d", i), al_data, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Parametrised single-port data memory controller for the pipelined CPU, replacing the ad-hoc byte-enable memory.
- Takes a size code (byte/half/word) plus full byte address, derives lanes internally.
- Performs little-endian lane write merge and sign/zero-extended loads, with one-cycle registered read latency.
- Flags misaligned and out-of-range accesses as an address-error exception for the interrupt/exception unit.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, at least 2.
ADDR_W, 32, byte address width.
IDX_W, $clog2(DEPTH), word index width (derived, not overridden).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and words
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  load data valid, one cycle after acceptance
rsp_rdata  out  32  extended load data
exc_valid  out  1  address-error pulse, one cycle after acceptance
exc_store  out  1  1 = faulting access was a store
exc_badaddr  out  ADDR_W  faulting byte address

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: req_ready 0 while rst high; rsp_valid 0, rsp_rdata 0, exc_valid 0, exc_store 0, exc_badaddr 0. Memory contents are not reset.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready && !rst. Nothing is written or responded otherwise.
- FSM:
  - States RUN and CLEAR; CLEAR exists only with the optional feature.
  - Without the feature, the FSM is always RUN.
  - In RUN, req_ready = 1 in every cycle after rst deasserts (one request per cycle, back-to-back allowed).
- Legality check on the accepted request. The access is illegal when any of these holds:
  - req_size == 11;
  - half access with addr[0] == 1;
  - word access with addr[1:0] != 0;
  - addr[ADDR_W-1:2] >= DEPTH.
- Illegal access:
  - No memory write.
  - Next cycle: exc_valid = 1, exc_store = req_we, exc_badaddr = req_addr, rsp_valid = 0.
  - exc_store and exc_badaddr hold until the next exception.
- Legal store: committed at the accepting edge.
  - Byte: wdata[7:0] goes to lane addr[1:0] (lane 0 = bits 7:0).
  - Half: wdata[15:0] goes to bits [15:0] if addr[1] == 0, else [31:16].
  - Word: full overwrite. Other lanes are unchanged.
  - No response pulse.
- Legal load:
  - The word is read at the accepting edge into a register.
  - Next cycle, rsp_valid = 1 and rsp_rdata is the selected lane, extended to 32 bits.
  - Sign bit is bit 7 of the byte or bit 15 of the half.
  - rsp_rdata holds until the next load response.
- Pulses: rsp_valid and exc_valid are single-cycle unless the next request also qualifies. They are never both 1.
- Load after store: a load accepted the cycle after a store to the same word returns the merged new data, since the write precedes it by one edge.
- Reset mid-operation: rst high on the edge following an acceptance suppresses that response/exception; all outputs take reset values.

Optional Feature:
- Macro: DM_CLEAR_EN.
- Defined:
  - After rst deasserts, the FSM enters CLEAR.
  - It writes 0 to word index 0..DEPTH-1, one word per cycle, using an IDX_W counter.
  - req_ready = 0 for exactly DEPTH cycles, then RUN with req_ready = 1.
  - rst asserted during CLEAR restarts the clear from index 0 after deassertion.
- Not defined: no CLEAR state or counter; memory powers up undefined (X in simulation); req_ready = 1 from the first cycle after rst deasserts.

Decomposition:
- Package dm_pkg:
  - size codes SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - FSM state type (RUN, CLEAR);
  - function byte_mask(size, addr[1:0]) returning a 4-bit lane mask.
- Sub-module dm_load_align: combinational lane select and sign/zero extension. Inputs are word, addr[1:0], size and unsigned; output is 32-bit data. It is tested standalone.
- Storage array, write merge, legality check, FSM and output registers live in dm_ctrl.

Test Plan:
- Store word 0x87654321 @0x10, load word @0x10 next cycle -> rsp_valid one cycle after accept, rsp_rdata 0x87654321.
- Store byte 0xA5 @0x13. Then:
  - signed byte load @0x13 -> 0xFFFFFFA5;
  - unsigned byte load @0x13 -> 0x000000A5;
  - word load @0x10 -> 0xA5654321.
- Store half 0x8001 @0x12. Then:
  - signed half load @0x12 -> 0xFFFF8001;
  - unsigned half load @0x10 -> 0x00004321;
  - signed byte load @0x11 -> 0x00000043.
- Word load @0x22 -> exc_valid = 1, exc_store = 0, exc_badaddr 0x22, rsp_valid = 0. Half store 0xFFFF @0x11 -> exc_store = 1, word @0x10 unchanged.
- Out of range and reserved size, DEPTH = 1024:
  - word load @0x1000 -> exception, badaddr 0x1000;
  - size 11 @0x0 -> exception.
- Reset and clear:
  - rst on the edge after a load accept -> no rsp_valid.
  - With DM_CLEAR_EN, req_ready stays 0 exactly 1024 cycles after reset; any load then returns 0.
  - With DM_CLEAR_EN, rst at cycle 500 restarts a full 1024-cycle clear.
